prio_encoder_rr: RTL and testbench
==================================

# prio_encoder_rr

Parametrised, registered N-to-log2(N) priority encoder with enable, selectable fixed-priority or round-robin arbitration, and a valid/ready handshake on both sides. It is the next generation of the combinational 8-to-3 encoder in the combinational-logic library. It sits between request sources (interrupt lines, channel requests) and a consumer that needs one encoded index per transfer, with back-pressure.

## Interface
- N, default 8: number of request inputs; legal range 2..64.
- W, default $clog2(N): index width; derived, never overridden.
- MODE, default 0: 0 = fixed priority (highest set index wins); 1 = round-robin.
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset; synchronous and active-high.
- i  input  N  request vector.
- en  input  1  encode enable; sampled with `i`.
- in_valid  input  1  `i`/`en` are valid this cycle.
- in_ready  output  1  block accepts input this cycle.
- o  output  W  encoded winning index.
- hit  output  1  at least one request bit was set while enabled.
- multi  output  1  two or more request bits were set while enabled.
- out_valid  output  1  `o`/`hit`/`multi` hold a result.
- out_ready  input  1  consumer takes the result this cycle.

## Operation
- Transfer in ("accept") when `in_valid && in_ready`. Transfer out ("take") when `out_valid && out_ready`.
- `in_ready = !out_valid || out_ready`. This is a single output register with pass-through ready, with no bubble under continuous flow.
- On accept with `en=1` and `i != 0`:
  - MODE 0: `o` = highest set index.
  - MODE 1: `o` = first set index found scanning upward from pointer `ptr`, wrapping from N-1 to 0. Then `ptr <= (o == N-1) ? 0 : o+1`.
  - `hit <= 1`.
  - `multi <=` (popcount(i) >= 2).
- On accept with `en=0` or `i == 0`: `o <= 0`, `hit <= 0`, `multi <= 0`. `out_valid` still asserts (the result is "no hit"), and `ptr` is unchanged.
- `ptr` is W bits wide and exists in MODE 1 only. In MODE 0 it is tied to 0.
- Outputs hold stable while `out_valid && !out_ready`. Any change to `i` in that window is ignored.
- Simultaneous take and accept in one cycle: the new result replaces the old one, and `out_valid` stays 1.
- When N is not a power of two, indices N..2^W-1 are never produced.

## Timing
- Reset (`rst=1` at a clock edge) sets `o=0`, `hit=0`, `multi=0`, `out_valid=0`, `ptr=0`. `in_ready` then reads 1 combinationally.
- Reset mid-operation discards any pending result. `ptr` returns to 0.
- Latency: 1 cycle. A result accepted at edge k is visible, with `out_valid=1`, after edge k.
- Throughput: 1 result per cycle while `out_ready=1`.
- `out_valid` drops the cycle after a take with no concurrent accept.
- `in_ready` depends combinationally on `out_ready` only. There is no combinational path from `i` to any output.

## Test plan
- Reset/idle: assert `rst` for 2 cycles, `in_valid=0` -> `out_valid=0`, `o=0`, `hit=0`, `multi=0`, `in_ready=1`.
- Fixed priority, N=8, MODE 0, `out_ready=1`, `en=1`, `i` = 0000_0001, 0000_0100, 0100_0000, 0100_0101 on consecutive cycles:
  - Results `o` = 0, 2, 6, 6.
  - `hit=1` throughout.
  - `multi` = 0, 0, 0, 1.
  - One result per cycle.
- Enable off: `en=0`, `i` = 0000_0100 -> `out_valid=1`, `o=0`, `hit=0`, `multi=0`. In MODE 1, `ptr` is unchanged (check with a following `en=1`, `i=8'hFF`).
- Round-robin, N=8, MODE 1, `i=8'hFF` held for 10 accepts -> `o` = 0,1,2,3,4,5,6,7,0,1. Then `i` = 1000_0001 with `ptr=2` -> `o=7`, next `o=0`.
- Back-pressure: `out_ready=0` for 3 cycles after the first result (`i` = 0000_0100, `o=2`), with `i` changing meanwhile:
  - `in_ready=0`.
  - `o` holds at 2.
  - The result after release matches the input accepted on the release cycle.
- Non-power-of-two and reset mid-stream: N=5, MODE 1, `i=5'b11111` -> `o` = 0..4 then 0, never 5..7. Assert `rst` while `out_valid=1` -> next cycle `out_valid=0`, and the next accept yields `o=0`.

Source files
------------

// File: rtl/prio_encoder_rr_if.sv
// ---------------------------------------------------------------------------
// prio_encoder_rr_if
//   Handshake bundle between request sources, the encoder and the consumer.
//
//   Parameters
//     N : number of request lines
//     W : encoded index width, derived from N
//
//   Signals
//     i         request vector                 (source   -> encoder)
//     en        encode enable, sampled with i  (source   -> encoder)
//     in_valid  i/en are valid                 (source   -> encoder)
//     in_ready  encoder accepts this cycle     (encoder  -> source)
//     o         encoded winning index          (encoder  -> consumer)
//     hit       at least one enabled request   (encoder  -> consumer)
//     multi     two or more enabled requests   (encoder  -> consumer)
//     out_valid o/hit/multi hold a result      (encoder  -> consumer)
//     out_ready consumer takes the result      (consumer -> encoder)
//
//   Modports
//     master : environment side (drives requests and out_ready)
//     slave  : encoder side
// ---------------------------------------------------------------------------
interface prio_encoder_rr_if #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) ();

  logic [N-1:0] i;
  logic         en;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] o;
  logic         hit;
  logic         multi;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output i,
    output en,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  o,
    input  hit,
    input  multi,
    input  out_valid
  );

  modport slave (
    input  i,
    input  en,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output o,
    output hit,
    output multi,
    output out_valid
  );

endinterface

// File: rtl/prio_encoder_rr.sv
// ---------------------------------------------------------------------------
// prio_encoder_rr
//   Registered N-to-W priority encoder with enable and valid/ready handshake
//   on both sides. One output register with pass-through ready, so a full
//   stream flows at one result per cycle with no bubble.
//
//   Parameters
//     N    : request lines, 2..64
//     W    : index width, derived from N
//     MODE : 0 = fixed priority (highest set index wins)
//            1 = round-robin (first set index at or above ptr, wrapping)
//
//   Ports
//     clk  : rising-edge clock
//     rst  : synchronous, active-high reset
//     bus  : prio_encoder_rr_if.slave (request side and result side)
//
//   The only combinational output path is out_ready -> in_ready; the
//   request vector reaches the outputs through the result register only.
// ---------------------------------------------------------------------------
module prio_encoder_rr #(
  parameter int N    = 8,
  parameter int W    = $clog2(N),
  parameter int MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  prio_encoder_rr_if.slave  bus
);

  localparam logic [N-1:0] ZERO_N   = {N{1'b0}};
  localparam logic [N-1:0] ONE_N    = {{(N-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] ZERO_W   = {W{1'b0}};
  localparam logic [W-1:0] ONE_W    = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] LAST_IDX = W'(N - 1);

  // -------------------------------------------------------------------------
  // Encoding helpers
  // -------------------------------------------------------------------------

  // Highest set bit index; 0 when v is empty (caller gates with hit).
  function automatic logic [W-1:0] highest_idx(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = ZERO_W;
    for (int k = 0; k < N; k++) begin
      idx = v[k] ? W'(k) : idx;
    end
    return idx;
  endfunction

  // Lowest set bit index; 0 when v is empty.
  function automatic logic [W-1:0] lowest_idx(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = ZERO_W;
    for (int k = N - 1; k >= 0; k--) begin
      idx = v[k] ? W'(k) : idx;
    end
    return idx;
  endfunction

  // Round-robin pick: first request at or above p, otherwise wrap and take
  // the lowest request overall. Only indices < N can ever be returned.
  function automatic logic [W-1:0] rr_idx(input logic [N-1:0] v,
                                          input logic [W-1:0] p);
    logic [N-1:0] upper;
    for (int k = 0; k < N; k++) begin
      upper[k] = v[k] && (k >= int'(p));
    end
    return (upper != ZERO_N) ? lowest_idx(upper) : lowest_idx(v);
  endfunction

  // Two or more bits set: clearing the lowest set bit leaves something.
  function automatic logic multi_of(input logic [N-1:0] v);
    return (v & (v - ONE_N)) != ZERO_N;
  endfunction

  // -------------------------------------------------------------------------
  // Handshake and result datapath
  // -------------------------------------------------------------------------
  logic [W-1:0] o_r;
  logic         hit_r;
  logic         multi_r;
  logic         out_valid_r;
  logic [W-1:0] ptr_r;

  logic         in_ready_s;
  logic         accept_s;
  logic         take_s;
  logic         active_s;
  logic [W-1:0] win_s;
  logic [W-1:0] o_nxt_s;
  logic         hit_nxt_s;
  logic         multi_nxt_s;

  // Arbitration style is fixed at elaboration; ptr only exists in round-robin.
  if (MODE == 1) begin : g_rr
    logic [W-1:0] ptr_nxt_s;

    assign win_s = rr_idx(bus.i, ptr_r);

    // Pointer advance: move just past the winner on a real hit, else hold.
    always_comb begin
      ptr_nxt_s = ptr_r;
      if (accept_s && active_s) begin
        ptr_nxt_s = (win_s == LAST_IDX) ? ZERO_W : (win_s + ONE_W);
      end else begin
        ptr_nxt_s = ptr_r;
      end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
      if (rst) begin
        ptr_r <= ZERO_W;
      end else begin
        ptr_r <= ptr_nxt_s;
      end
    end
  end else begin : g_fixed
    assign win_s = highest_idx(bus.i);
    assign ptr_r = ZERO_W;
  end

  // Handshake qualifiers and next result value.
  always_comb begin
    in_ready_s  = !out_valid_r || bus.out_ready;
    accept_s    = bus.in_valid && in_ready_s;
    take_s      = out_valid_r && bus.out_ready;
    active_s    = bus.en && (bus.i != ZERO_N);
    o_nxt_s     = ZERO_W;
    hit_nxt_s   = 1'b0;
    multi_nxt_s = 1'b0;
    if (active_s) begin
      o_nxt_s     = win_s;
      hit_nxt_s   = 1'b1;
      multi_nxt_s = multi_of(bus.i);
    end else begin
      // Disabled or empty request still produces a "no hit" result.
      o_nxt_s     = ZERO_W;
      hit_nxt_s   = 1'b0;
      multi_nxt_s = 1'b0;
    end
  end

  // Result register: load on accept (also covers take+accept), clear
  // out_valid on a take with nothing new, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_r         <= ZERO_W;
      hit_r       <= 1'b0;
      multi_r     <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      o_r         <= o_nxt_s;
      hit_r       <= hit_nxt_s;
      multi_r     <= multi_nxt_s;
      out_valid_r <= 1'b1;
    end else if (take_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.o         = o_r;
  assign bus.hit       = hit_r;
  assign bus.multi     = multi_r;
  assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// ---------------------------------------------------------------------------
// tb_prio_encoder_rr
//   Three encoder instances share one clock and reset:
//     d0 : N=8 MODE 0, d1 : N=8 MODE 1, d2 : N=5 MODE 1.
//   Stimulus pushes hand-computed results into a per-instance queue; a
//   monitor per instance pops and compares whenever a result is taken.
// ---------------------------------------------------------------------------
module tb_prio_encoder_rr;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  prio_encoder_rr_if #(.N(8)) b0 ();
  prio_encoder_rr_if #(.N(8)) b1 ();
  prio_encoder_rr_if #(.N(5)) b2 ();

  prio_encoder_rr #(.N(8), .MODE(0)) d0 (.clk(clk), .rst(rst), .bus(b0.slave));
  prio_encoder_rr #(.N(8), .MODE(1)) d1 (.clk(clk), .rst(rst), .bus(b1.slave));
  prio_encoder_rr #(.N(5), .MODE(1)) d2 (.clk(clk), .rst(rst), .bus(b2.slave));

  typedef struct packed {
    logic [2:0] o;
    logic       hit;
    logic       multi;
  } res_t;

  res_t q0[$];
  res_t q1[$];
  res_t q2[$];
  res_t e0, e1, e2;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int sel, input logic [2:0] o, input logic h, input logic m);
    res_t r;
    r = '{o: o, hit: h, multi: m};
    case (sel)
      0: q0.push_back(r);
      1: q1.push_back(r);
      2: q2.push_back(r);
      default: ;
    endcase
  endtask

  // Drive one instance; the others sit idle with out_ready high.
  task automatic drive(input int sel, input logic [7:0] iv, input logic env,
                       input logic vld, input logic ordy);
    b0.i = 8'h00; b0.en = 1'b0; b0.in_valid = 1'b0; b0.out_ready = 1'b1;
    b1.i = 8'h00; b1.en = 1'b0; b1.in_valid = 1'b0; b1.out_ready = 1'b1;
    b2.i = 5'h00; b2.en = 1'b0; b2.in_valid = 1'b0; b2.out_ready = 1'b1;
    case (sel)
      0: begin b0.i = iv;      b0.en = env; b0.in_valid = vld; b0.out_ready = ordy; end
      1: begin b1.i = iv;      b1.en = env; b1.in_valid = vld; b1.out_ready = ordy; end
      2: begin b2.i = iv[4:0]; b2.en = env; b2.in_valid = vld; b2.out_ready = ordy; end
      default: ;
    endcase
  endtask

  // One cycle: drive just after the rising edge, then move to the falling
  // edge where the caller and the monitors sample.
  task automatic go(input int sel, input logic [7:0] iv, input logic env,
                    input logic vld, input logic ordy);
    @(posedge clk);
    #1;
    drive(sel, iv, env, vld, ordy);
    @(negedge clk);
  endtask

  // Monitors: a result is taken when out_valid && out_ready at the next edge.
  always @(negedge clk) begin
    if (b0.out_valid === 1'b1 && b0.out_ready === 1'b1) begin
      if (q0.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL d0_unexpected: got result o=%0d, expected none", b0.o);
      end else begin
        e0 = q0.pop_front();
        check("d0_o",     8'(b0.o),     8'(e0.o));
        check("d0_hit",   8'(b0.hit),   8'(e0.hit));
        check("d0_multi", 8'(b0.multi), 8'(e0.multi));
      end
    end
  end

  always @(negedge clk) begin
    if (b1.out_valid === 1'b1 && b1.out_ready === 1'b1) begin
      if (q1.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL d1_unexpected: got result o=%0d, expected none", b1.o);
      end else begin
        e1 = q1.pop_front();
        check("d1_o",     8'(b1.o),     8'(e1.o));
        check("d1_hit",   8'(b1.hit),   8'(e1.hit));
        check("d1_multi", 8'(b1.multi), 8'(e1.multi));
      end
    end
  end

  always @(negedge clk) begin
    if (b2.out_valid === 1'b1 && b2.out_ready === 1'b1) begin
      if (q2.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL d2_unexpected: got result o=%0d, expected none", b2.o);
      end else begin
        e2 = q2.pop_front();
        check("d2_o",     8'(b2.o),        8'(e2.o));
        check("d2_range", 8'(b2.o < 3'd5), 8'd1);
        check("d2_hit",   8'(b2.hit),      8'(e2.hit));
        check("d2_multi", 8'(b2.multi),    8'(e2.multi));
      end
    end
  end

  initial begin
    rst = 1'b1;
    drive(0, 8'h00, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);

    // Reset / idle state
    check("rst_d0_out_valid", 8'(b0.out_valid), 8'd0);
    check("rst_d0_o",         8'(b0.o),         8'd0);
    check("rst_d0_hit",       8'(b0.hit),       8'd0);
    check("rst_d0_multi",     8'(b0.multi),     8'd0);
    check("rst_d0_in_ready",  8'(b0.in_ready),  8'd1);
    check("rst_d1_out_valid", 8'(b1.out_valid), 8'd0);
    check("rst_d2_out_valid", 8'(b2.out_valid), 8'd0);

    // Fixed priority, back-to-back
    push(0, 3'd0, 1'b1, 1'b0); go(0, 8'h01, 1'b1, 1'b1, 1'b1);
    push(0, 3'd2, 1'b1, 1'b0); go(0, 8'h04, 1'b1, 1'b1, 1'b1);
    check("fp_stream_valid1", 8'(b0.out_valid), 8'd1);
    push(0, 3'd6, 1'b1, 1'b0); go(0, 8'h40, 1'b1, 1'b1, 1'b1);
    check("fp_stream_valid2", 8'(b0.out_valid), 8'd1);
    push(0, 3'd6, 1'b1, 1'b1); go(0, 8'h45, 1'b1, 1'b1, 1'b1);
    check("fp_stream_valid3", 8'(b0.out_valid), 8'd1);

    // Enable off gives a valid "no hit" result
    push(0, 3'd0, 1'b0, 1'b0); go(0, 8'h04, 1'b0, 1'b1, 1'b1);
    go(0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("en_off_valid", 8'(b0.out_valid), 8'd1);
    go(0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("fp_valid_drop", 8'(b0.out_valid), 8'd0);
    check("fp_queue_empty", 8'(q0.size()), 8'd0);

    // Back-pressure: result held, input ignored, release accepts new input
    push(0, 3'd2, 1'b1, 1'b0); go(0, 8'h04, 1'b1, 1'b1, 1'b1);
    go(0, 8'h80, 1'b1, 1'b1, 1'b0);
    check("bp_in_ready0", 8'(b0.in_ready), 8'd0);
    check("bp_hold_o0",   8'(b0.o),        8'd2);
    go(0, 8'h10, 1'b1, 1'b1, 1'b0);
    check("bp_in_ready1", 8'(b0.in_ready), 8'd0);
    check("bp_hold_o1",   8'(b0.o),        8'd2);
    go(0, 8'h01, 1'b1, 1'b1, 1'b0);
    check("bp_in_ready2", 8'(b0.in_ready), 8'd0);
    check("bp_hold_o2",   8'(b0.o),        8'd2);
    check("bp_hold_valid", 8'(b0.out_valid), 8'd1);
    push(0, 3'd3, 1'b1, 1'b0); go(0, 8'h08, 1'b1, 1'b1, 1'b1);
    check("bp_release_ready", 8'(b0.in_ready), 8'd1);
    go(0, 8'h00, 1'b0, 1'b0, 1'b1);
    go(0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("bp_valid_drop", 8'(b0.out_valid), 8'd0);

    // Round-robin sweep, N=8
    for (int k = 0; k < 10; k++) begin
      push(1, 3'(k % 8), 1'b1, 1'b1);
      go(1, 8'hFF, 1'b1, 1'b1, 1'b1);
    end
    // ptr=2: 1000_0001 -> 7, then 0
    push(1, 3'd7, 1'b1, 1'b1); go(1, 8'h81, 1'b1, 1'b1, 1'b1);
    push(1, 3'd0, 1'b1, 1'b1); go(1, 8'h81, 1'b1, 1'b1, 1'b1);
    // Enable off keeps ptr at 1
    push(1, 3'd0, 1'b0, 1'b0); go(1, 8'h04, 1'b0, 1'b1, 1'b1);
    push(1, 3'd1, 1'b1, 1'b1); go(1, 8'hFF, 1'b1, 1'b1, 1'b1);
    go(1, 8'h00, 1'b0, 1'b0, 1'b1);
    go(1, 8'h00, 1'b0, 1'b0, 1'b1);
    check("rr_valid_drop", 8'(b1.out_valid), 8'd0);
    check("rr_queue_empty", 8'(q1.size()), 8'd0);

    // Round-robin, N=5: 0..4 then 0, then 1
    for (int k = 0; k < 7; k++) begin
      push(2, 3'(k % 5), 1'b1, 1'b1);
      go(2, 8'h1F, 1'b1, 1'b1, 1'b1);
    end
    go(2, 8'h00, 1'b0, 1'b0, 1'b0);
    check("n5_pending_valid", 8'(b2.out_valid), 8'd1);
    check("n5_pending_o",     8'(b2.o),         8'd1);

    // Reset mid-stream discards the pending result and rewinds ptr
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q2.delete();
    drive(2, 8'h00, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("midrst_valid", 8'(b2.out_valid), 8'd0);
    check("midrst_o",     8'(b2.o),         8'd0);
    push(2, 3'd0, 1'b1, 1'b1); go(2, 8'h1F, 1'b1, 1'b1, 1'b1);
    go(2, 8'h00, 1'b0, 1'b0, 1'b1);
    go(2, 8'h00, 1'b0, 1'b0, 1'b1);
    check("n5_valid_drop", 8'(b2.out_valid), 8'd0);

    check("end_q0_empty", 8'(q0.size()), 8'd0);
    check("end_q1_empty", 8'(q1.size()), 8'd0);
    check("end_q2_empty", 8'(q2.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
